// File: rtl/noc_params.sv
// Router-wide parameters shared by the allocation stages.
// Port order matches the router's physical port numbering.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request_i,
  input  logic         grant_valid_i,
  output logic [N-1:0] grant_o
);

  localparam int              PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W:0]  N_EXT = (PTR_W + 1)'(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_req_rot;
  logic [PTR_W-1:0] w_off;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_winner;
  logic             w_fire;

  // Rotate so the pointer position lands on bit 0, then find the lowest set bit.
  assign w_req_rot = N'({request_i, request_i} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = PTR_W'(k);
      end
    end
  end

  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT) : w_sum[PTR_W-1:0];
  assign w_fire   = grant_valid_i && (|request_i);

  always_comb begin
    grant_o = '0;
    if (w_fire) begin
      grant_o[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_winner == LAST) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, one free downstream VC is
// handed to one requesting input VC each cycle, round-robin across requesters.
module vc_allocator #(
  parameter  int PORT_NUM = noc_params::PORT_NUM,
  parameter  int VC_NUM   = noc_params::VC_NUM,
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic              [PORT_NUM-1:0][VC_NUM-1:0] request_i,
  input  noc_params::port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i,
  input  logic              [PORT_NUM-1:0][VC_NUM-1:0] vc_release_i,
  output logic              [PORT_NUM-1:0][VC_NUM-1:0] vc_valid_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
  output logic              [PORT_NUM-1:0][VC_NUM-1:0] vc_busy_o
);

  localparam int REQ_NUM = PORT_NUM * VC_NUM;

  logic [PORT_NUM-1:0][VC_NUM-1:0] r_busy;
  logic [PORT_NUM-1:0][VC_NUM-1:0] w_busy_next;
  logic [PORT_NUM-1:0][VC_NUM-1:0] w_cand  [PORT_NUM];
  logic [PORT_NUM-1:0][VC_NUM-1:0] w_grant [PORT_NUM];
  logic [PORT_NUM-1:0]             w_free_any;
  logic [PORT_NUM-1:0]             w_grant_any;
  logic [VC_SIZE-1:0]              w_free_vc [PORT_NUM];

  // Targets outside 0..PORT_NUM-1 match no output port and are dropped here.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          w_cand[o][p][v] = request_i[p][v] && (int'(out_port_i[p][v]) == o);
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      w_free_vc[o] = '0;
      for (int d = VC_NUM - 1; d >= 0; d--) begin
        if (!r_busy[o][d]) begin
          w_free_vc[o] = VC_SIZE'(d);
        end
      end
    end
  end

  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
    assign w_free_any[gi]  = ~&r_busy[gi];
    assign w_grant_any[gi] = |w_grant[gi];

    round_robin_arbiter #(
      .N (REQ_NUM)
    ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .request_i     (w_cand[gi]),
      .grant_valid_i (w_free_any[gi]),
      .grant_o       (w_grant[gi])
    );
  end

  // Each requester targets one port, so at most one arbiter can hit it.
  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int p = 0; p < PORT_NUM; p++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            if (w_grant[o][p][v]) begin
              vc_valid_o[p][v] = 1'b1;
              vc_new_o[p][v]   = w_free_vc[o];
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int d = 0; d < VC_NUM; d++) begin
        w_busy_next[o][d] = (r_busy[o][d] & ~vc_release_i[o][d]) |
                            (w_grant_any[o] && (w_free_vc[o] == VC_SIZE'(d)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign vc_busy_o = r_busy;

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: a per-cycle vector table followed by
// hand-written parallel-port and asynchronous-reset sequences.
module tb_vc_allocator;
  import noc_params::*;

  localparam int P = 5;
  localparam int V = 2;
  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;
  logic  [P-1:0][V-1:0]      request_i;
  port_t [P-1:0][V-1:0]      out_port_i;
  logic  [P-1:0][V-1:0]      vc_release_i;
  logic  [P-1:0][V-1:0]      vc_valid_o;
  logic  [P-1:0][V-1:0][0:0] vc_new_o;
  logic  [P-1:0][V-1:0]      vc_busy_o;

  int checks = 0;
  int errors = 0;

  // Bit r of req/ev/en is requester r = p*2+v; bit o*2+d of rel/eb is VC d of port o.
  typedef struct {
    logic [9:0] req;
    logic [2:0] tgt;
    logic [9:0] rel;
    logic [9:0] ev;
    logic [9:0] en;
    logic [9:0] eb;
  } vec_t;

  vec_t vecs [NV];

  vc_allocator #(
    .PORT_NUM (P),
    .VC_NUM   (V)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .request_i    (request_i),
    .out_port_i   (out_port_i),
    .vc_release_i (vc_release_i),
    .vc_valid_o   (vc_valid_o),
    .vc_new_o     (vc_new_o),
    .vc_busy_o    (vc_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_tgt(input logic [2:0] t);
    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < V; v++) begin
        out_port_i[p][v] = port_t'(t);
      end
    end
  endtask

  initial begin
    //           req      tgt   rel      ev       en       eb
    vecs[0]  = '{10'h004, 3'd4, 10'h000, 10'h004, 10'h000, 10'h000};
    vecs[1]  = '{10'h000, 3'd4, 10'h000, 10'h000, 10'h000, 10'h100};
    vecs[2]  = '{10'h061, 3'd1, 10'h000, 10'h001, 10'h000, 10'h100};
    vecs[3]  = '{10'h060, 3'd1, 10'h000, 10'h020, 10'h020, 10'h104};
    vecs[4]  = '{10'h040, 3'd1, 10'h000, 10'h000, 10'h000, 10'h10C};
    vecs[5]  = '{10'h040, 3'd1, 10'h008, 10'h000, 10'h000, 10'h10C};
    vecs[6]  = '{10'h040, 3'd1, 10'h000, 10'h040, 10'h040, 10'h104};
    vecs[7]  = '{10'h000, 3'd1, 10'h10C, 10'h000, 10'h000, 10'h10C};
    vecs[8]  = '{10'h080, 3'd2, 10'h000, 10'h080, 10'h000, 10'h000};
    vecs[9]  = '{10'h201, 3'd2, 10'h000, 10'h200, 10'h200, 10'h010};
    vecs[10] = '{10'h001, 3'd2, 10'h020, 10'h000, 10'h000, 10'h030};
    vecs[11] = '{10'h201, 3'd2, 10'h000, 10'h001, 10'h001, 10'h010};
    vecs[12] = '{10'h200, 3'd2, 10'h020, 10'h000, 10'h000, 10'h030};
    vecs[13] = '{10'h201, 3'd2, 10'h000, 10'h200, 10'h200, 10'h010};
    vecs[14] = '{10'h001, 3'd2, 10'h030, 10'h000, 10'h000, 10'h030};
    vecs[15] = '{10'h001, 3'd2, 10'h000, 10'h001, 10'h000, 10'h000};
    vecs[16] = '{10'h000, 3'd2, 10'h010, 10'h000, 10'h000, 10'h010};
    vecs[17] = '{10'h3FF, 3'd5, 10'h000, 10'h000, 10'h000, 10'h000};
    vecs[18] = '{10'h3FF, 3'd7, 10'h000, 10'h000, 10'h000, 10'h000};
    vecs[19] = '{10'h000, 3'd0, 10'h020, 10'h000, 10'h000, 10'h000};
    vecs[20] = '{10'h004, 3'd3, 10'h000, 10'h004, 10'h000, 10'h000};
    vecs[21] = '{10'h008, 3'd3, 10'h040, 10'h008, 10'h008, 10'h040};
    vecs[22] = '{10'h000, 3'd3, 10'h080, 10'h000, 10'h000, 10'h080};
    vecs[23] = '{10'h000, 3'd0, 10'h000, 10'h000, 10'h000, 10'h000};

    // Reset: outputs forced low even with a live request.
    rst = 1'b0;
    request_i = 10'h004;
    vc_release_i = '0;
    set_tgt(3'd4);
    @(negedge clk);
    chk("reset valid", vc_valid_o, 10'h000);
    chk("reset new", vc_new_o, 10'h000);
    chk("reset busy", vc_busy_o, 10'h000);
    request_i = '0;
    #1 rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      request_i = vecs[i].req;
      vc_release_i = vecs[i].rel;
      set_tgt(vecs[i].tgt);
      @(negedge clk);
      $display("cycle %0d: req=%h tgt=%0d rel=%h -> valid=%h new=%h busy=%h",
               i, vecs[i].req, vecs[i].tgt, vecs[i].rel, vc_valid_o, vc_new_o, vc_busy_o);
      chk($sformatf("c%0d valid", i), vc_valid_o, vecs[i].ev);
      chk($sformatf("c%0d new", i), vc_new_o, vecs[i].en);
      chk($sformatf("c%0d busy", i), vc_busy_o, vecs[i].eb);
    end

    // Parallel ports: (0,0)->WEST, (1,1)->EAST, (2,0)->NORTH in one cycle.
    @(posedge clk);
    #1;
    vc_release_i = '0;
    set_tgt(3'd0);
    out_port_i[0][0] = WEST;
    out_port_i[1][1] = EAST;
    out_port_i[2][0] = NORTH;
    request_i = 10'h019;
    @(negedge clk);
    $display("parallel: valid=%h new=%h busy=%h", vc_valid_o, vc_new_o, vc_busy_o);
    chk("parallel valid", vc_valid_o, 10'h019);
    chk("parallel new", vc_new_o, 10'h000);

    @(posedge clk);
    #1;
    out_port_i[0][1] = NORTH;
    request_i = 10'h002;
    @(negedge clk);
    $display("fill north: valid=%h new=%h busy=%h", vc_valid_o, vc_new_o, vc_busy_o);
    chk("parallel busy", vc_busy_o, 10'h144);
    chk("north vc1 valid", vc_valid_o, 10'h002);
    chk("north vc1 new", vc_new_o, 10'h002);

    @(posedge clk);
    #1;
    out_port_i[2][1] = SOUTH;
    request_i = 10'h020;
    @(negedge clk);
    $display("pre-reset: valid=%h new=%h busy=%h", vc_valid_o, vc_new_o, vc_busy_o);
    chk("pre-reset busy", vc_busy_o, 10'h14C);
    chk("pre-reset valid", vc_valid_o, 10'h020);

    // Asynchronous reset in the middle of a cycle, away from any edge.
    #2 rst = 1'b0;
    #1;
    $display("async reset: valid=%h new=%h busy=%h", vc_valid_o, vc_new_o, vc_busy_o);
    chk("async busy", vc_busy_o, 10'h000);
    chk("async valid", vc_valid_o, 10'h000);
    chk("async new", vc_new_o, 10'h000);
    request_i = '0;
    @(posedge clk);
    @(negedge clk);
    chk("held reset busy", vc_busy_o, 10'h000);
    #2 rst = 1'b1;

    // (0,0) and (2,0) to NORTH: the pointer restarts at 0, so (0,0) wins.
    @(posedge clk);
    #1;
    out_port_i[0][0] = NORTH;
    out_port_i[2][0] = NORTH;
    request_i = 10'h011;
    @(negedge clk);
    $display("post-reset: valid=%h new=%h busy=%h", vc_valid_o, vc_new_o, vc_busy_o);
    chk("post-reset valid", vc_valid_o, 10'h001);
    chk("post-reset new", vc_new_o, 10'h000);

    @(posedge clk);
    #1;
    request_i = '0;
    @(negedge clk);
    chk("post-reset busy", vc_busy_o, 10'h004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_allocator.md
# vc_allocator

Virtual-channel allocation stage that serves every input buffer of a router while those buffers wait in their VA state. It tracks which downstream VCs on each output port are busy. Each cycle it grants, per output port, one free downstream VC to one requesting input VC, chosen round-robin. The grant and VC identifier drive the input buffers' `vc_valid_i` / `vc_new_i`, and the buffers then move to SA.

## Interface
- `PORT_NUM`, default `noc_params::PORT_NUM` (5): router ports (LOCAL, NORTH, SOUTH, WEST, EAST).
- `VC_NUM`, default `noc_params::VC_NUM` (2): VCs per port; `VC_SIZE = $clog2(VC_NUM)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `request_i`  in  [PORT_NUM][VC_NUM]  input VC (p,v) is in VA and requests a downstream VC.
- `out_port_i`  in  port_t [PORT_NUM][VC_NUM]  output port targeted by input VC (p,v); meaningful only while its request is high.
- `vc_release_i`  in  [PORT_NUM][VC_NUM]  one-cycle pulse: downstream VC d on output port o becomes free (tail forwarded).
- `vc_valid_o`  out  [PORT_NUM][VC_NUM]  grant to input VC (p,v), combinational, same cycle as the request.
- `vc_new_o`  out  [PORT_NUM][VC_NUM][VC_SIZE]  granted downstream VC id; valid only with `vc_valid_o`.
- `vc_busy_o`  out  [PORT_NUM][VC_NUM]  registered busy map per output port/downstream VC.

## Operation
- State: `busy[o][d]` and one round-robin pointer `ptr[o]` per output port, in range 0..PORT_NUM*VC_NUM-1.
- Requester index is r = p*VC_NUM + v.
- Per output port o, candidates are requesters with `request_i` high and `out_port_i == o`.
- If a candidate exists and some `busy[o][d]==0`:
  - The winner is the first candidate at or after `ptr[o]`, wrapping around.
  - The winner gets the lowest-index free d.
  - `vc_valid_o` is high for the winner and `vc_new_o = d`.
- At most one grant per output port per cycle. At most one grant per input VC per cycle, since each input VC targets exactly one port. Different output ports grant independently in the same cycle.
- No free VC on port o means no grant on o and `ptr[o]` is unchanged. Requests stay pending; there is no starvation, because the pointer only moves past a winner.
- On a grant, at the next edge: `busy[o][d] <= 1` and `ptr[o] <= (winner+1) mod (PORT_NUM*VC_NUM)`.
- Release: `busy_next = (busy & ~vc_release_i) | granted`.
  - A VC released in cycle N is grantable from cycle N+1, never in cycle N.
  - A release on a VC that is already free is ignored (stays free).
  - A release and a grant on the same VC in the same cycle cannot occur, because grants go only to free VCs.
- Any requester whose `out_port_i` is outside 0..PORT_NUM-1 is ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - `busy` = 0 and every `ptr` = 0.
  - `vc_valid_o` = 0 and `vc_new_o` = 0, both forced while reset is asserted.
  - `vc_busy_o` = 0.
- Grant latency is 0 cycles: request in cycle N gives `vc_valid_o` in cycle N.
  - The input buffer samples the grant at the end of cycle N and enters SA.
  - Its request falls in cycle N+1.
- A request held high after its grant has been sampled is treated as a new request; requesters must drop it.
- `vc_busy_o` reflects a grant from cycle N starting in cycle N+1.
- Reset asserted mid-operation clears all allocations; granted-but-unreleased VCs are lost by design, since the whole router resets together.

## Structure
- `noc_params` holds `PORT_NUM`, `VC_NUM`, `VC_SIZE` and `port_t`. No new package types are needed.
- One sub-module, `round_robin_arbiter`, instantiated per output port:
  - Parameter N.
  - Inputs: request vector [N] and `grant_valid` (a free VC exists).
  - Outputs: one-hot grant.
  - Owns its pointer with asynchronous active-low reset.
- Free-VC selection is a lowest-index priority encoder in the top level.

## Test plan
- Reset, then input VC (1,0) requests EAST (port 4) in cycle 0 → `vc_valid_o[1][0]`=1 and `vc_new_o[1][0]`=0 in cycle 0; `vc_busy_o[4][0]`=1 from cycle 1.
- Three requesters (0,0), (2,1), (3,0) target NORTH (port 1) continuously, each dropping its request after its grant → grants in cycles 0,1 go to (0,0)→VC0, (2,1)→VC1. (3,0) gets nothing while both VCs are busy. Pulse `vc_release_i[1][1]` in cycle 4 → (3,0) is granted VC1 in cycle 5, not cycle 4.
- Fairness: (0,0) and (4,1) re-request SOUTH after every release; each release is pulsed the cycle after its grant → grants alternate (0,0), (4,1), (0,0), …; neither requester wins twice in a row.
- Parallel ports: in one cycle (0,0)→WEST, (1,1)→EAST, (2,0)→NORTH → all three granted VC0 in the same cycle.
- Release on already-free VC [2][1] → `vc_busy_o` unchanged (0). Release on a busy VC in the same cycle a different VC on that port is granted → both updates apply at the edge.
- Assert `rst`=0 mid-cycle with 4 VCs busy → `vc_busy_o` and `vc_valid_o` go to 0 immediately, without waiting for a clock edge. After deassertion, the next request to port 1 gets VC0 and arbitration starts from requester index 0.
